// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save compression tree: PARM_PP partial products -> sum/carry pair + MSB correction.
// Optional input register stage selected by `CSA_TREE_IN_REG_EN.
module csa_tree_pipe #(
    parameter int unsigned PARM_MANT          = 23,
    parameter int unsigned PARM_PP            = 13,
    parameter int unsigned PARM_LVL_PER_STAGE = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic [PARM_PP*(2*PARM_MANT+3)-1:0]    pp_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [2*PARM_MANT+2:0]                pp_sum_o,
    output logic [2*PARM_MANT+2:0]                pp_carry_o,
    output logic                                  msb_cor_o
);

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int unsigned calc_lvls(input int unsigned n);
        int unsigned m;
        int unsigned l;
        m = n;
        l = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (m > 2) begin
                m = m - m / 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    // Row count at the input of level lvl.
    function automatic int unsigned cnt_at(input int unsigned n, input int unsigned lvl);
        int unsigned m;
        m = n;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < lvl && m > 2) m = m - m / 3;
        end
        return m;
    endfunction

    localparam int unsigned W   = 2 * PARM_MANT + 3;
    localparam int unsigned LPS = PARM_LVL_PER_STAGE;
    localparam int unsigned L   = calc_lvls(PARM_PP);
    localparam int unsigned S   = (L + LPS - 1) / LPS;

    typedef logic [PARM_PP-1:0][W-1:0] rows_t;

    rows_t          lvl_in  [L];
    rows_t          lvl_out [L];
    logic [L-1:0]   par_in;
    logic [L-1:0]   par_out;

    rows_t          st_q    [S];
    rows_t          st_d    [S];
    logic [S-1:0]   st_par;
    logic [S-1:0]   st_pd;
    logic [S-1:0]   st_v;
    logic [S-1:0]   st_ld;
    logic [S-1:0]   st_src_v;

    rows_t          fe_rows;
    logic           fe_v;

`ifdef CSA_TREE_IN_REG_EN
    // Input register stage ahead of the first compressor level.
    rows_t in_q;
    logic  in_v;
    logic  in_ld_c;

    assign in_ld_c = !in_v || st_ld[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_v <= 1'b0;
            in_q <= '0;
        end else if (in_ld_c) begin
            in_v <= valid_i;
            if (valid_i) in_q <= pp_i;
        end
    end

    assign fe_rows = in_q;
    assign fe_v    = in_v;
    assign ready_o = in_ld_c;
`else
    assign fe_rows = pp_i;
    assign fe_v    = valid_i;
    assign ready_o = st_ld[0];
`endif

    // Compressor levels; a level at a stage boundary reads the previous stage register.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int unsigned N = cnt_at(PARM_PP, l);
        localparam int unsigned G = N / 3;
        localparam int unsigned P = N - 3 * G;

        rows_t        row_c;
        logic [G-1:0] disc;

        if (l == 0) begin : g_src_fe
            assign lvl_in[l] = fe_rows;
            assign par_in[l] = 1'b0;
        end else if (l % LPS == 0) begin : g_src_reg
            assign lvl_in[l] = st_q[l/LPS-1];
            assign par_in[l] = st_par[l/LPS-1];
        end else begin : g_src_comb
            assign lvl_in[l] = lvl_out[l-1];
            assign par_in[l] = par_out[l-1];
        end

        for (genvar i = 0; i < G; i++) begin : g_fa
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] c;
            logic [W-1:0] maj;
            assign a   = lvl_in[l][3*i];
            assign b   = lvl_in[l][3*i+1];
            assign c   = lvl_in[l][3*i+2];
            assign maj = (a & b) | (a & c) | (b & c);
            assign row_c[2*i]   = a ^ b ^ c;
            assign row_c[2*i+1] = {maj[W-2:0], 1'b0};
            assign disc[i]      = maj[W-1];
        end

        for (genvar j = 0; j < P; j++) begin : g_pass
            assign row_c[2*G+j] = lvl_in[l][3*G+j];
        end

        if (N - G < PARM_PP) begin : g_zero
            assign row_c[PARM_PP-1:N-G] = '0;
        end

        assign lvl_out[l] = row_c;
        assign par_out[l] = par_in[l] ^ (^disc);
    end

    // Stage k captures the output of its last level; load enables chain back from the output.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned LAST = (((k + 1) * LPS < L) ? (k + 1) * LPS : L) - 1;

        assign st_d[k]  = lvl_out[LAST];
        assign st_pd[k] = par_out[LAST];

        if (k == 0) begin : g_v0
            assign st_src_v[k] = fe_v;
        end else begin : g_vk
            assign st_src_v[k] = st_v[k-1];
        end

        if (k == S - 1) begin : g_ld_last
            assign st_ld[k] = !st_v[k] || ready_i;
        end else begin : g_ld_mid
            assign st_ld[k] = !st_v[k] || st_ld[k+1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_v   <= '0;
            st_par <= '0;
            for (int k = 0; k < S; k++) st_q[k] <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (st_ld[k]) begin
                    st_v[k] <= st_src_v[k];
                    if (st_src_v[k]) begin
                        st_q[k]   <= st_d[k];
                        st_par[k] <= st_pd[k];
                    end
                end
            end
        end
    end

    assign valid_o    = st_v[S-1];
    assign pp_sum_o   = st_q[S-1][0];
    assign pp_carry_o = st_q[S-1][1];
    assign msb_cor_o  = st_par[S-1];

    // Rows above the final pair are always zero in the last stage.
    logic unused_rows;
    assign unused_rows = ^st_q[S-1][PARM_PP-1:2];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe: directed and random vectors, stall, reset and a 3-input instance.
module tb_csa_tree_pipe;

    localparam int unsigned MANT = 23;
    localparam int unsigned PP   = 13;
    localparam int unsigned W    = 2 * MANT + 3;
`ifdef CSA_TREE_IN_REG_EN
    localparam int LAT  = 4;
    localparam int LAT3 = 2;
`else
    localparam int LAT  = 3;
    localparam int LAT3 = 1;
`endif
    localparam int CAP = LAT;

    typedef struct {
        logic [W-1:0] m;
        logic         b;
        int           acc;
        bit           chk;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              valid_i;
    logic              ready_o;
    logic [PP*W-1:0]   pp;
    logic              valid_o;
    logic              ready_i;
    logic [W-1:0]      sum_o;
    logic [W-1:0]      carry_o;
    logic              msb_o;

    logic              valid3_i;
    logic              ready3_o;
    logic [3*W-1:0]    pp3;
    logic              valid3_o;
    logic [W-1:0]      sum3_o;
    logic [W-1:0]      carry3_o;
    logic              msb3_o;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc_n = 0;
    int   em_n  = 0;
    bit   rnd_rdy = 0;

    csa_tree_pipe #(.PARM_MANT(MANT), .PARM_PP(PP), .PARM_LVL_PER_STAGE(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .pp_i(pp),
        .valid_o(valid_o), .ready_i(ready_i), .pp_sum_o(sum_o), .pp_carry_o(carry_o),
        .msb_cor_o(msb_o)
    );

    csa_tree_pipe #(.PARM_MANT(MANT), .PARM_PP(3), .PARM_LVL_PER_STAGE(1)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid3_i), .ready_o(ready3_o), .pp_i(pp3),
        .valid_o(valid3_o), .ready_i(1'b1), .pp_sum_o(sum3_o), .pp_carry_o(carry3_o),
        .msb_cor_o(msb3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rnd_rdy) begin
        #1 ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W+5:0] model(input logic [PP*W-1:0] v);
        logic [W+5:0] s;
        s = '0;
        for (int k = 0; k < PP; k++) s = s + (W+6)'(v[k*W +: W]);
        return s;
    endfunction

    // Hold the vector until accepted, then log the expected result.
    task automatic send(input logic [PP*W-1:0] v, input logic [W-1:0] m, input logic b, input bit chk);
        exp_t e;
        valid_i = 1'b1;
        pp      = v;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ready_o) begin
                e.m = m; e.b = b; e.acc = cyc; e.chk = chk;
                sb.push_back(e);
                acc_n++;
                @(posedge clk); #1;
                valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 64'd1, 64'd0);
        valid_i = 1'b0;
    endtask

    task automatic send_model(input logic [PP*W-1:0] v, input bit chk);
        logic [W+5:0] s;
        s = model(v);
        send(v, s[W-1:0], s[W], chk);
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares every output transfer, checks hold while stalled.
    logic [W-1:0] prev_s, prev_c;
    logic         prev_m;
    bit           prev_stall = 0;

    always @(negedge clk) begin
        exp_t         e;
        logic [W:0]   tot;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_sum", 64'(sum_o), 64'(prev_s));
                check("stall_carry", 64'(carry_o), 64'(prev_c));
                check("stall_msb", 64'(msb_o), 64'(prev_m));
            end
            if (valid_o && ready_i) begin
                em_n++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e   = sb.pop_front();
                    tot = {1'b0, sum_o} + {1'b0, carry_o};
                    check("sum_mod", 64'(tot[W-1:0]), 64'(e.m));
                    check("msb_bit", 64'(tot[W] ^ msb_o), 64'(e.b));
                    check("carry_lsb", 64'(carry_o[0]), 64'd0);
                    if (e.chk) check("latency", 64'(cyc - e.acc), 64'(LAT));
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_s     = sum_o;
            prev_c     = carry_o;
            prev_m     = msb_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PP*W-1:0] v;
        logic [W-1:0]    all1;
        bit              seen;
        int              k3;

        rst_n    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        pp       = '0;
        valid3_i = 1'b0;
        pp3      = '0;

        #12;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_sum", 64'(sum_o), 64'd0);
        check("rst_carry", 64'(carry_o), 64'd0);
        check("rst_msb", 64'(msb_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;

        // pp0=5, pp1=7
        v = '0;
        v[0 +: W] = W'(5);
        v[W +: W] = W'(7);
        send(v, W'(12), 1'b0, 1'b1);
        drain();

        // All ones: 13*(2^49-1) = 12*2^49 + (2^49-13)
        all1 = '1;
        v = '1;
        send(v, all1 - W'(12), 1'b0, 1'b1);
        // Thirteen copies of 2^48 = 6*2^49 + 2^48
        v = '0;
        for (int k = 0; k < PP; k++) v[k*W + W-1] = 1'b1;
        send(v, W'(1) << (W-1), 1'b0, 1'b1);
        // Three copies of 2^48 = 2^49 + 2^48
        v = '0;
        for (int k = 0; k < 3; k++) v[k*W + W-1] = 1'b1;
        send(v, W'(1) << (W-1), 1'b1, 1'b1);
        // One pp at each position: 1+2+...+13 = 91
        v = '0;
        for (int k = 0; k < PP; k++) v[k*W +: W] = W'(k + 1);
        send(v, W'(91), 1'b0, 1'b1);
        drain();

        // Random vectors, ready_i held high
        for (int n = 0; n < 700; n++) begin
            v = '0;
            for (int k = 0; k < PP; k++) v[k*W +: W] = W'({$urandom(), $urandom()});
            send_model(v, 1'b1);
        end
        drain();

        // Random vectors with random backpressure
        rnd_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            v = '0;
            for (int k = 0; k < PP; k++) v[k*W +: W] = W'({$urandom(), $urandom()});
            send_model(v, 1'b0);
        end
        rnd_rdy = 0;
        #1 ready_i = 1'b1;
        drain();

        // Stall: six back-to-back vectors, ready_i low for five cycles
        seen = 0;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    v = '0;
                    for (int k = 0; k < PP; k++) v[k*W +: W] = W'({$urandom(), $urandom()});
                    send_model(v, 1'b0);
                end
            end
            begin
                @(posedge clk); #1;
                ready_i = 1'b0;
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    if (!ready_o && !seen) begin
                        seen = 1;
                        check("occupancy", 64'(acc_n - em_n), 64'(CAP));
                    end
                    @(posedge clk); #1;
                end
                ready_i = 1'b1;
            end
        join
        check("ready_drop", 64'(seen), 64'd1);
        drain();

        // Reset with two vectors in flight
        v = '0; v[0 +: W] = W'(3);
        send_model(v, 1'b0);
        v = '0; v[0 +: W] = W'(9);
        send_model(v, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(valid_o), 64'd0);
        check("async_rst_sum", 64'(sum_o), 64'd0);
        check("async_rst_carry", 64'(carry_o), 64'd0);
        check("async_rst_msb", 64'(msb_o), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        k3 = em_n;
        v = '0; v[2*W +: W] = W'(100); v[5*W +: W] = W'(23);
        send(v, W'(123), 1'b0, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_count", 64'(em_n - k3), 64'd1);

        // Three-input instance: pp=1,2,4
        pp3      = {W'(4), W'(2), W'(1)};
        valid3_i = 1'b1;
        @(negedge clk);
        check("pp3_ready", 64'(ready3_o), 64'd1);
        @(posedge clk); #1;
        valid3_i = 1'b0;
        k3 = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (valid3_o) begin
                k3 = t;
                break;
            end
        end
        check("pp3_latency", 64'(k3), 64'(LAT3));
        check("pp3_sum", 64'({1'b0, sum3_o} + {1'b0, carry3_o}), 64'd7);
        check("pp3_msb", 64'(msb3_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
